fetch_stage: RTL and testbench

- IF stage plus IF/ID pipeline register for the 5-stage RV32I core.
- Holds PCF and fetches instructions over a single-outstanding request/response instruction-memory port.
- Presents InstrD/PCD/PCPlus4D to decode.
- Consumes StallF/StallD/FlushD from the hazard unit and the EX-stage redirect (PCSrcE/PCTargetE).
- Reports memory wait back through FetchBusyF, which the hazard unit ORs into its stalls.

---
 rtl/fetch_stage.sv | 162 ++++++++++++++++
 tb/tb_fetch_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// RV32I fetch stage with IF/ID pipeline register.
// Keeps one instruction-memory request in flight and buffers a response that arrives while the pipe is held.
module fetch_stage #(
    parameter int unsigned       XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_PC  = 32'h0000_0000,
    parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
    output logic            FetchBusyF
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    state_t            r_state;
    logic [XLEN-1:0]   r_pcf;
    logic [31:0]       r_fb_instr;
    logic              r_fb_valid;
    logic [31:0]       r_instr_d;
    logic [XLEN-1:0]   r_pc_d;
    logic [XLEN-1:0]   r_pcplus4_d;
    logic              r_valid_d;

    logic              w_ready;
    logic              w_adv;
    logic [31:0]       w_instr_f;
    logic [XLEN-1:0]   w_pcf_plus4;
    logic [XLEN-1:0]   w_target;

    assign w_pcf_plus4 = r_pcf + PC_STEP;
    assign w_target    = PCTargetE & ALIGN_MASK;

    // Instruction availability, advance decision and request generation
    always_comb begin
        w_ready   = r_fb_valid | ((r_state == ST_WAIT) & imem_rvalid);
        w_adv     = w_ready & ~StallF & ~StallD & ~PCSrcE;
        if (r_fb_valid) begin
            w_instr_f = r_fb_instr;
        end else begin
            w_instr_f = imem_rdata;
        end
        imem_req  = 1'b0;
        imem_addr = '0;
        // A buffered instruction already covers PCF, so IDLE only requests with the buffer empty
        if (!resetn) begin
            imem_req  = 1'b0;
        end else if ((r_state == ST_IDLE) & ~r_fb_valid & ~PCSrcE) begin
            imem_req  = 1'b1;
            imem_addr = r_pcf;
        end else if ((r_state == ST_WAIT) & imem_rvalid & w_adv) begin
            imem_req  = 1'b1;
            imem_addr = w_pcf_plus4;
        end else begin
            imem_req  = 1'b0;
        end
        FetchBusyF = resetn & ~w_ready;
    end

    // PC, request-tracking state and fetch buffer
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_pcf      <= RESET_PC;
            r_fb_valid <= 1'b0;
            r_fb_instr <= NOP_INSTR;
        end else begin
            if (PCSrcE) begin
                r_pcf <= w_target;
            end else if (w_adv) begin
                r_pcf <= w_pcf_plus4;
            end else begin
                r_pcf <= r_pcf;
            end

            if (PCSrcE) begin
                r_fb_valid <= 1'b0;
                case (r_state)
                    ST_WAIT:    r_state <= imem_rvalid ? ST_IDLE : ST_DISCARD;
                    ST_DISCARD: r_state <= imem_rvalid ? ST_IDLE : ST_DISCARD;
                    default:    r_state <= ST_IDLE;
                endcase
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (imem_req) begin
                            r_state <= ST_WAIT;
                        end
                        if (r_fb_valid & w_adv) begin
                            r_fb_valid <= 1'b0;
                        end
                    end
                    ST_WAIT: begin
                        if (imem_rvalid & ~w_adv) begin
                            r_state    <= ST_IDLE;
                            r_fb_valid <= 1'b1;
                            r_fb_instr <= imem_rdata;
                        end else if (r_fb_valid & w_adv) begin
                            r_state    <= ST_IDLE;
                            r_fb_valid <= 1'b0;
                        end
                    end
                    ST_DISCARD: begin
                        if (imem_rvalid) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_instr_d   <= NOP_INSTR;
            r_pc_d      <= '0;
            r_pcplus4_d <= '0;
            r_valid_d   <= 1'b0;
        end else if (FlushD) begin
            r_instr_d   <= NOP_INSTR;
            r_valid_d   <= 1'b0;
        end else if (StallD) begin
            r_instr_d   <= r_instr_d;
            r_valid_d   <= r_valid_d;
        end else if (w_adv) begin
            r_instr_d   <= w_instr_f;
            r_pc_d      <= r_pcf;
            r_pcplus4_d <= w_pcf_plus4;
            r_valid_d   <= 1'b1;
        end else begin
            r_instr_d   <= NOP_INSTR;
            r_valid_d   <= 1'b0;
        end
    end

    assign InstrD   = r_instr_d;
    assign PCD      = r_pc_d;
    assign PCPlus4D = r_pcplus4_d;
    assign ValidD   = r_valid_d;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency memory, request/hold level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
    logic [31:0] PCTargetE = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'hDEAD_BEEF;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD, FetchBusyF;

    int tests = 0;
    int fails = 0;
    int lat   = 1;
    int cyc   = 0;
    logic chk_en = 1'b0;

    fetch_stage dut (
        .clk(clk), .resetn(resetn), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .ValidD(ValidD), .FetchBusyF(FetchBusyF)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk_b(input string name, input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Memory: answers each request with mem[a] = a | 0x100 after lat cycles
    logic        pend = 1'b0;
    logic [31:0] p_addr = 32'h0;
    int          due = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (pend && cyc == due) begin
            imem_rvalid = 1'b1;
            imem_rdata  = p_addr | 32'h100;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!resetn) begin
            pend = 1'b0;
        end else begin
            if (imem_rvalid) pend = 1'b0;
            if (imem_req) begin
                pend   = 1'b1;
                p_addr = imem_addr;
                due    = cyc + lat;
            end
        end
    end

    // Reference model: tracks the outstanding request (live or stale), the held instruction,
    // the next fetch PC and the decode-side view.
    logic [31:0] m_pc = 32'h0, m_hold_instr = 32'h0;
    logic [31:0] m_d_instr = 32'h13, m_d_pc = 32'h0, m_d_pc4 = 32'h0;
    logic        m_out = 1'b0, m_live = 1'b0, m_hold = 1'b0, m_d_valid = 1'b0;
    logic        t_arr, t_ready, t_take, e_req, e_busy;
    logic [31:0] e_addr, t_instr;

    initial forever begin
        @(negedge clk);
        t_arr   = m_out && m_live && imem_rvalid;
        t_ready = m_hold || t_arr;
        t_take  = t_ready && !StallF && !StallD && !PCSrcE;
        e_addr  = 32'h0;
        if (!resetn || PCSrcE) begin
            e_req = 1'b0;
        end else if (!m_out && !m_hold) begin
            e_req = 1'b1; e_addr = m_pc;
        end else if (t_arr && t_take) begin
            e_req = 1'b1; e_addr = m_pc + 32'd4;
        end else begin
            e_req = 1'b0;
        end
        e_busy = resetn && !t_ready;
        if (chk_en) begin
            chk_b("m_req", imem_req, e_req);
            if (e_req) chk("m_addr", imem_addr, e_addr);
            chk_b("m_busy", FetchBusyF, e_busy);
            chk_b("m_validd", ValidD, m_d_valid);
            chk("m_instrd", InstrD, m_d_instr);
            chk("m_pcd", PCD, m_d_pc);
            chk("m_pcplus4d", PCPlus4D, m_d_pc4);
        end
        if (!resetn) begin
            m_pc = 32'h0; m_out = 1'b0; m_live = 1'b0; m_hold = 1'b0;
            m_d_instr = 32'h13; m_d_pc = 32'h0; m_d_pc4 = 32'h0; m_d_valid = 1'b0;
        end else begin
            t_instr = m_hold ? m_hold_instr : imem_rdata;
            if (FlushD) begin
                m_d_instr = 32'h13; m_d_valid = 1'b0;
            end else if (!StallD) begin
                if (t_take) begin
                    m_d_instr = t_instr; m_d_pc = m_pc; m_d_pc4 = m_pc + 32'd4; m_d_valid = 1'b1;
                end else begin
                    m_d_instr = 32'h13; m_d_valid = 1'b0;
                end
            end
            if (m_out && imem_rvalid) m_out = 1'b0;
            if (e_req) begin m_out = 1'b1; m_live = 1'b1; end
            if (PCSrcE) begin
                m_live = 1'b0; m_hold = 1'b0;
            end else if (t_arr && !t_take) begin
                m_hold = 1'b1; m_hold_instr = imem_rdata;
            end else if (t_take && m_hold) begin
                m_hold = 1'b0;
            end
            if (PCSrcE)      m_pc = PCTargetE & 32'hFFFF_FFFC;
            else if (t_take) m_pc = m_pc + 32'd4;
        end
    end

    task automatic drive(input logic sf, input logic sd, input logic fd, input logic ps,
                         input logic [31:0] pt);
        @(posedge clk);
        #1;
        StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = pt;
    endtask

    task automatic wait_req(input string name, input logic [31:0] a, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == a) found = 1'b1;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL %s: no request for %08h within %0d cycles", name, a, budget);
        end
    endtask

    task automatic next_req(input string name, input logic [31:0] a, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (imem_req) begin
                found = 1'b1;
                chk(name, imem_addr, a);
            end
        end
        if (!found) begin
            tests++; fails++;
            $display("FAIL %s: no request within %0d cycles, expected %08h", name, budget, a);
        end
    endtask

    task automatic wait_valid_pc(input string name, input logic [31:0] pc, input logic [31:0] instr,
                                 input logic [31:0] pc4, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (ValidD && PCD == pc) begin
                found = 1'b1;
                chk({name, "_instr"}, InstrD, instr);
                chk({name, "_pc4"}, PCPlus4D, pc4);
            end
        end
        if (!found) begin
            tests++; fails++;
            $display("FAIL %s: PCD %08h never valid within %0d cycles", name, pc, budget);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        @(posedge clk); #1; chk_en = 1'b1;
        @(negedge clk);
        chk_b("rst_req", imem_req, 1'b0);
        chk_b("rst_busy", FetchBusyF, 1'b0);
        chk("rst_instrd", InstrD, 32'h13);
        chk_b("rst_validd", ValidD, 1'b0);

        // 1-cycle memory streaming
        drive(0, 0, 0, 0, 0); resetn = 1'b1;
        @(negedge clk); chk_b("s_req0", imem_req, 1'b1); chk("s_addr0", imem_addr, 32'h0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk); chk("s_addr1", imem_addr, 32'h4); chk_b("s_busy1", FetchBusyF, 1'b0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("s_pcd2", PCD, 32'h0); chk("s_instr2", InstrD, 32'h100);
        chk_b("s_valid2", ValidD, 1'b1); chk("s_pc4_2", PCPlus4D, 32'h4);
        repeat (6) drive(0, 0, 0, 0, 0);
        @(negedge clk); chk("s_pcd8", PCD, 32'h18); chk("s_instr8", InstrD, 32'h118);

        // Latency 3
        drive(0, 0, 0, 0, 0); lat = 3;
        drive(0, 0, 0, 0, 0);
        @(negedge clk); chk_b("l_busy_a", FetchBusyF, 1'b1); chk("l_pcd_a", PCD, 32'h20);
        drive(0, 0, 0, 0, 0);
        @(negedge clk); chk_b("l_busy_b", FetchBusyF, 1'b1); chk_b("l_valid_b", ValidD, 1'b0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk); chk_b("l_busy_c", FetchBusyF, 1'b0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk); chk("l_pcd_d", PCD, 32'h24); chk("l_instr_d", InstrD, 32'h124);
        wait_valid_pc("l_next", 32'h28, 32'h128, 32'h2C, 8);

        // One-cycle reset while a request is outstanding
        drive(0, 0, 0, 0, 0); resetn = 1'b0; lat = 1;
        @(negedge clk); chk_b("r_req", imem_req, 1'b0); chk_b("r_busy", FetchBusyF, 1'b0);
        drive(0, 0, 0, 0, 0); resetn = 1'b1;
        @(negedge clk);
        chk("r_instrd", InstrD, 32'h13); chk_b("r_validd", ValidD, 1'b0);
        chk("r_pcd", PCD, 32'h0); chk("r_pc4d", PCPlus4D, 32'h0);
        chk_b("r_req0", imem_req, 1'b1); chk("r_addr0", imem_addr, 32'h0);

        // Stall while the response for 0x8 arrives
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 0);
            @(negedge clk);
            chk_b("st_req", imem_req, 1'b0); chk_b("st_busy", FetchBusyF, 1'b0);
            chk("st_pcd", PCD, 32'h4); chk("st_instr", InstrD, 32'h104);
        end
        drive(0, 0, 0, 0, 0);
        @(negedge clk); chk_b("st_norefetch", imem_req, 1'b0);
        wait_valid_pc("st_rel", 32'h8, 32'h108, 32'hC, 3);

        // Redirect one cycle after the request to 0x10
        drive(0, 0, 0, 0, 0); lat = 3;
        wait_req("rd_req10", 32'h10, 6);
        drive(0, 0, 0, 1, 32'h43);
        drive(0, 0, 0, 0, 0);
        next_req("rd_addr", 32'h40, 6);
        wait_valid_pc("rd_deliv", 32'h40, 32'h140, 32'h44, 8);

        // Flush together with stall
        drive(0, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk); chk("fl_instr", InstrD, 32'h13); chk_b("fl_valid", ValidD, 1'b0);

        // Wrap-around at the top of the address space (redirect also beats StallF)
        drive(1, 0, 0, 1, 32'hFFFF_FFFE); lat = 1;
        drive(0, 0, 0, 0, 0);
        wait_req("w_top", 32'hFFFF_FFFC, 8);
        wait_req("w_zero", 32'h0, 3);
        wait_valid_pc("w_deliv", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 3);
        wait_valid_pc("w_after", 32'h0, 32'h100, 32'h4, 4);

        repeat (3) drive(0, 0, 0, 0, 0);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
